uart_rx_edge_bit_timer: RTL and testbench
=========================================

# uart_rx_edge_bit_timer

Parametrised bit-timing engine for the UART receiver: counts oversampling edges within a bit and bits within a frame for any prescale from 4 up to 2^PRESCALE_W-1. It latches its configuration at frame start, flags mid-bit majority-vote sample windows, and emits bit-done and frame-done strobes. It sits between the RX FSM, which drives `enable`, and the data sampler and deserializer.

## Interface
- PRESCALE_W, 6, width of prescale and edge_cnt; maximum prescale is 2^PRESCALE_W-1
- BIT_CNT_W, 4, width of frame_bits and bit_cnt
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- enable  in  1  run request from the RX FSM; low aborts and clears
- prescale  in  PRESCALE_W  oversampling ratio; latched at frame start
- frame_bits  in  BIT_CNT_W  bits per frame including start, parity and stop; latched at frame start
- edge_cnt  out  PRESCALE_W  edge index within the current bit
- bit_cnt  out  BIT_CNT_W  bit index within the frame
- sample_stb  out  1  high during the three mid-bit sample edges
- sample_idx  out  2  0, 1 or 2 while sample_stb is high, else 0
- bit_done  out  1  one-cycle pulse at each bit boundary
- frame_done  out  1  one-cycle pulse at frame completion
- cfg_err  out  1  latched configuration invalid; level signal

## Operation
- States: IDLE, RUN, HOLD, ERR.
- Reset values: state is IDLE; edge_cnt, bit_cnt, sample_idx, sample_stb, bit_done, frame_done and cfg_err are all 0.
- IDLE, enable=1:
  - Latch prescale into ps_q and frame_bits into fb_q.
  - Config is valid when ps_q >= 4 and fb_q >= 2; valid goes to RUN, invalid goes to ERR.
  - edge_cnt and bit_cnt stay 0.
- RUN, each edge:
  - If edge_cnt == ps_q-1: edge_cnt <= 0, bit_cnt <= bit_cnt+1, bit_done <= 1.
  - Otherwise edge_cnt <= edge_cnt+1.
- RUN, frame end (edge_cnt == ps_q-1 and bit_cnt == fb_q-1):
  - Go to HOLD.
  - bit_cnt <= fb_q (saturated), edge_cnt <= 0.
  - bit_done and frame_done both pulse.
- HOLD: counters frozen at bit_cnt = fb_q, edge_cnt = 0 until enable drops. No wrap and no new frame.
- ERR: cfg_err = 1; counters held at 0; no strobes.
- enable=0 in any state: next state IDLE; counters, strobes and cfg_err are cleared on the same edge. This also applies mid-frame.
- Sample window:
  - mid = ps_q >> 1.
  - sample_stb is decoded from registered state: it is high in RUN when edge_cnt is mid-1, mid or mid+1.
  - sample_idx = edge_cnt - (mid-1) inside the window.
  - Odd prescale is legal; mid rounds down.
- Changes to prescale or frame_bits during RUN, HOLD or ERR are ignored until the next IDLE→enable.
- Arithmetic:
  - Counters are unsigned at their own widths.
  - Comparisons use ps_q-1 and fb_q-1 computed at full width; no overflow is possible because ps_q >= 4 and fb_q >= 2.
  - fb_q equal to 2^BIT_CNT_W-1 is legal; bit_cnt saturates there.

## Timing
- Latency from enable sampled high to the first increment: 1 cycle. The IDLE→RUN edge does not count.
- Clock cycles from entering RUN to frame_done: fb_q × ps_q.
- bit_done and frame_done are registered. Each is high for exactly one cycle, in the cycle where edge_cnt = 0 and bit_cnt holds its new value.
- sample_stb and sample_idx have zero latency relative to edge_cnt.
- cfg_err rises 1 cycle after the enable rising edge in IDLE. It falls in the cycle after enable is sampled low.
- Reset assertion is asynchronous at any time. Release is synchronous to CLK and ends in IDLE.

## Structure
- Shared package `uart_rx_pkg`:
  - MIN_PRESCALE = 4, MIN_FRAME_BITS = 2.
  - State enum edge_bit_state_t: IDLE, RUN, HOLD, ERR.
  - Sample-window offset constants.
- One sub-module, `uart_sample_window`: purely decodes mid, sample_stb and sample_idx from ps_q and edge_cnt.
- Top level holds the FSM, config latches and counters.

## Test plan
- prescale=8, frame_bits=10, enable held high:
  - bit_done pulses on every 8th cycle after RUN entry.
  - frame_done occurs on cycle 80 with bit_cnt=10.
  - sample_stb is high when edge_cnt is 3, 4 or 5.
- prescale=5 (odd), frame_bits=2:
  - mid=2, sample window at edge_cnt 1, 2, 3.
  - frame_done after 10 cycles.
- prescale=63 (PRESCALE_W=6 max):
  - edge_cnt reaches 62 and wraps to 0 with no overflow.
  - Sample window at edge_cnt 30, 31, 32.
- prescale=3 or frame_bits=1:
  - cfg_err=1 one cycle later; counters stay 0 and no strobes occur.
  - Dropping enable clears cfg_err.
- Mid-frame abort and config change:
  - Drop enable at bit_cnt=4, edge_cnt=6: next cycle everything is 0 and state is IDLE.
  - Change prescale 16→8 during RUN: no effect until the next frame.
- Reset mid-frame:
  - Pulse RST low at bit_cnt=3: all outputs are 0 immediately.
  - After release with enable high, a new frame starts from bit 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, minimum legal
// configuration, and the placement of the three-edge majority-vote window.
package uart_rx_pkg;

  localparam int MIN_PRESCALE   = 4;
  localparam int MIN_FRAME_BITS = 2;

  // Window spans mid-SAMPLE_PRE .. mid+SAMPLE_POST
  localparam int SAMPLE_PRE  = 1;
  localparam int SAMPLE_POST = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } edge_bit_state_t;

endpackage

// File: rtl/uart_sample_window.sv
// Decodes the mid-bit sample window and its index from the latched prescale
// and the current edge count; purely combinational.
module uart_sample_window #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_run,
  input  logic [PRESCALE_W-1:0] i_ps_q,
  input  logic [PRESCALE_W-1:0] i_edge_cnt,
  output logic                  o_sample_stb,
  output logic [1:0]            o_sample_idx
);
  import uart_rx_pkg::*;

  // One extra bit so mid+1 never wraps for the largest prescale
  logic [PRESCALE_W:0] w_mid;
  logic [PRESCALE_W:0] w_lo;
  logic [PRESCALE_W:0] w_hi;
  logic [PRESCALE_W:0] w_edge;
  logic [1:0]          w_idx;
  logic                w_in_win;

  assign w_mid    = {1'b0, (i_ps_q >> 1)};
  assign w_lo     = w_mid - (PRESCALE_W+1)'(SAMPLE_PRE);
  assign w_hi     = w_mid + (PRESCALE_W+1)'(SAMPLE_POST);
  assign w_edge   = {1'b0, i_edge_cnt};
  assign w_idx    = 2'(w_edge - w_lo);
  assign w_in_win = i_run && (w_edge >= w_lo) && (w_edge <= w_hi);

  // Window strobe and index, forced to zero outside the window
  always_comb begin
    o_sample_stb = 1'b0;
    o_sample_idx = 2'd0;
    if (w_in_win) begin
      o_sample_stb = 1'b1;
      o_sample_idx = w_idx;
    end else begin
      o_sample_stb = 1'b0;
      o_sample_idx = 2'd0;
    end
  end

endmodule

// File: rtl/uart_rx_edge_bit_timer.sv
// Bit-timing engine for the UART receiver: counts oversampling edges per bit
// and bits per frame, with configuration captured at frame start.
module uart_rx_edge_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);
  import uart_rx_pkg::*;

  edge_bit_state_t       r_state, w_state_nxt;
  logic [PRESCALE_W-1:0] r_ps_q, w_ps_nxt;
  logic [BIT_CNT_W-1:0]  r_fb_q, w_fb_nxt;
  logic [PRESCALE_W-1:0] r_edge_cnt, w_edge_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_nxt;
  logic                  r_bit_done, w_bit_done_nxt;
  logic                  r_frame_done, w_frame_done_nxt;
  logic                  r_cfg_err, w_cfg_err_nxt;
  logic                  w_cfg_ok, w_edge_last, w_bit_last;

  assign w_cfg_ok    = (prescale >= PRESCALE_W'(MIN_PRESCALE)) &&
                       (frame_bits >= BIT_CNT_W'(MIN_FRAME_BITS));
  assign w_edge_last = (r_edge_cnt == (r_ps_q - PRESCALE_W'(1)));
  assign w_bit_last  = (r_bit_cnt == (r_fb_q - BIT_CNT_W'(1)));

  // Next-state, config capture, counter and strobe computation
  always_comb begin
    w_state_nxt      = r_state;
    w_ps_nxt         = r_ps_q;
    w_fb_nxt         = r_fb_q;
    w_edge_nxt       = r_edge_cnt;
    w_bit_nxt        = r_bit_cnt;
    w_bit_done_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_cfg_err_nxt    = r_cfg_err;
    if (!enable) begin
      w_state_nxt   = IDLE;
      w_edge_nxt    = '0;
      w_bit_nxt     = '0;
      w_cfg_err_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_ps_nxt   = prescale;
          w_fb_nxt   = frame_bits;
          w_edge_nxt = '0;
          w_bit_nxt  = '0;
          if (w_cfg_ok) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt   = ERR;
            w_cfg_err_nxt = 1'b1;
          end
        end
        RUN: begin
          if (w_edge_last) begin
            w_edge_nxt     = '0;
            w_bit_done_nxt = 1'b1;
            if (w_bit_last) begin
              // Saturate at fb_q so HOLD reports the full frame length
              w_bit_nxt        = r_fb_q;
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = HOLD;
            end else begin
              w_bit_nxt = r_bit_cnt + BIT_CNT_W'(1);
            end
          end else begin
            w_edge_nxt = r_edge_cnt + PRESCALE_W'(1);
          end
        end
        HOLD: begin
          w_state_nxt = HOLD;
        end
        ERR: begin
          w_edge_nxt    = '0;
          w_bit_nxt     = '0;
          w_cfg_err_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_edge_nxt  = '0;
          w_bit_nxt   = '0;
        end
      endcase
    end
  end

  // State, configuration and counter registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_ps_q       <= '0;
      r_fb_q       <= '0;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_bit_done   <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ps_q       <= w_ps_nxt;
      r_fb_q       <= w_fb_nxt;
      r_edge_cnt   <= w_edge_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_bit_done   <= w_bit_done_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_cfg_err    <= w_cfg_err_nxt;
    end
  end

  uart_sample_window #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sample_window (
    .i_run        (r_state == RUN),
    .i_ps_q       (r_ps_q),
    .i_edge_cnt   (r_edge_cnt),
    .o_sample_stb (sample_stb),
    .o_sample_idx (sample_idx)
  );

  assign edge_cnt   = r_edge_cnt;
  assign bit_cnt    = r_bit_cnt;
  assign bit_done   = r_bit_done;
  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_uart_rx_edge_bit_timer.sv
// Randomised and directed bench for uart_rx_edge_bit_timer against a model
// that tracks elapsed cycles since frame start and derives counters from it.
module tb_uart_rx_edge_bit_timer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] prescale = 6'd0;
  logic [3:0] frame_bits = 4'd0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_done, frame_done, cfg_err;

  uart_rx_edge_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .prescale(prescale),
    .frame_bits(frame_bits), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sample_stb(sample_stb), .sample_idx(sample_idx), .bit_done(bit_done),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad = 0;

  // model: mode 0 idle, 1 running/holding (t = cycles since RUN entry), 2 error
  int m_mode = 0, m_t = 0, m_ps = 0, m_fb = 0;
  bit m_bd = 1'b0, m_fd = 1'b0;
  int cyc = 0, run_cyc = 0, fd_cyc = -1, max_edge = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    m_bd = 1'b0;
    m_fd = 1'b0;
    if (!enable) begin
      m_mode = 0;
      m_t = 0;
    end else if (m_mode == 0) begin
      m_ps = int'(prescale);
      m_fb = int'(frame_bits);
      m_t = 0;
      m_mode = (m_ps >= 4 && m_fb >= 2) ? 1 : 2;
      if (m_mode == 1) run_cyc = cyc;
    end else if (m_mode == 1 && m_t < m_ps * m_fb) begin
      m_t++;
      m_bd = (m_t % m_ps == 0);
      m_fd = (m_t == m_ps * m_fb);
    end
  endtask

  task automatic check_all();
    int e, b, mid, idx;
    bit stb;
    e = 0; b = 0; stb = 1'b0; idx = 0;
    if (m_mode == 1) begin
      if (m_t == m_ps * m_fb) begin
        e = 0; b = m_fb;
      end else begin
        e = m_t % m_ps; b = m_t / m_ps;
        mid = m_ps / 2;
        stb = (e >= mid - 1) && (e <= mid + 1);
        idx = stb ? e - (mid - 1) : 0;
      end
    end
    check_val("edge_cnt", 32'(edge_cnt), 32'(e));
    check_val("bit_cnt", 32'(bit_cnt), 32'(b));
    check_val("sample_stb", 32'(sample_stb), 32'(stb));
    check_val("sample_idx", 32'(sample_idx), 32'(idx));
    check_val("bit_done", 32'(bit_done), 32'(m_bd));
    check_val("frame_done", 32'(frame_done), 32'(m_fd));
    check_val("cfg_err", 32'(cfg_err), 32'(m_mode == 2));
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    model_edge();
    #1;
    if (frame_done === 1'b1) fd_cyc = cyc - run_cyc;
    if (int'(edge_cnt) > max_edge) max_edge = int'(edge_cnt);
    check_all();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic set_in(input logic en, input int ps, input int fb);
    enable = en;
    prescale = 6'(ps);
    frame_bits = 4'(fb);
  endtask

  task automatic reset_pulse();
    #2 RST = 1'b0;
    #1;
    m_mode = 0; m_t = 0; m_bd = 1'b0; m_fd = 1'b0;
    check_all();
    #2 RST = 1'b1;
  endtask

  initial begin
    #3;
    check_all();
    @(negedge CLK);
    RST = 1'b1;

    // nominal frame: 8x oversampling, 10 bits, then HOLD
    set_in(1'b1, 8, 10); fd_cyc = -1;
    run_cycles(85);
    check_val("fd_latency_8x10", 32'(fd_cyc), 32'd80);
    set_in(1'b0, 8, 10); run_cycles(2);

    // odd prescale
    set_in(1'b1, 5, 2); fd_cyc = -1;
    run_cycles(14);
    check_val("fd_latency_5x2", 32'(fd_cyc), 32'd10);
    set_in(1'b0, 5, 2); run_cycles(2);

    // maximum prescale and maximum frame length
    set_in(1'b1, 63, 15); max_edge = 0; fd_cyc = -1;
    run_cycles(63 * 15 + 3);
    check_val("edge_max_63", 32'(max_edge), 32'd62);
    check_val("fd_latency_63x15", 32'(fd_cyc), 32'd945);
    set_in(1'b0, 63, 15); run_cycles(2);

    // invalid configurations
    set_in(1'b1, 3, 10); run_cycles(5);
    set_in(1'b0, 3, 10); run_cycles(2);
    set_in(1'b1, 8, 1); run_cycles(5);
    set_in(1'b0, 8, 1); run_cycles(2);

    // abort at bit 4, edge 6
    set_in(1'b1, 8, 10); run_cycles(1 + 4 * 8 + 6);
    set_in(1'b0, 8, 10); run_cycles(2);

    // prescale change during RUN is ignored until next frame
    set_in(1'b1, 16, 3); run_cycles(20);
    prescale = 6'd8; run_cycles(40);
    set_in(1'b0, 8, 3); run_cycles(1);
    set_in(1'b1, 8, 3); run_cycles(30);
    set_in(1'b0, 8, 3); run_cycles(1);

    // asynchronous reset mid-frame, then a fresh frame
    set_in(1'b1, 8, 10); run_cycles(1 + 3 * 8 + 2);
    reset_pulse();
    run_cycles(30);
    set_in(1'b0, 8, 10); run_cycles(1);

    // randomised segments
    for (int s = 0; s < 30; s++) begin
      int ps, fb, len;
      ps = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 63);
      fb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 15);
      len = $urandom_range(1, ps * fb + 12);
      set_in(1'b1, ps, fb);
      run_cycles(len / 2 + 1);
      if ($urandom_range(0, 1) == 1) begin
        prescale = 6'($urandom);
        frame_bits = 4'($urandom);
      end
      if ($urandom_range(0, 5) == 0) reset_pulse();
      run_cycles(len / 2 + 1);
      enable = 1'b0;
      run_cycles($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
